cc_branch_unit: RTL and testbench

CC_BRANCH_UNIT -- requirements
Module: cc_branch_unit

---
 rtl/cc_branch_unit_if.sv | 35 +++
 rtl/cc_branch_unit.sv | 121 ++++++++++++
 tb/tb_cc_branch_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cc_branch_unit_if.sv
// Handshake and status bundle of the condition-code / branch-resolve unit.
// The slave modport is the unit itself; master is whoever drives instructions and the PC side.
interface cc_branch_unit_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
);
    logic              instr_valid_in;
    logic              instr_ready_out;
    logic              we_reg_in;
    logic              br_in;
    logic [2:0]        nzp_mask_in;
    logic [DATA_W-1:0] alu_result_in;
    logic              flush_in;
    logic              pc_ready_in;
    logic              br_valid_out;
    logic              br_taken_out;
    logic [2:0]        cc_out;
    logic [2:0]        phase_out;
    logic [1:0]        state_out;
    logic [CNT_W-1:0]  retire_cnt_out;

    modport slave (
        input  instr_valid_in, we_reg_in, br_in, nzp_mask_in, alu_result_in,
               flush_in, pc_ready_in,
        output instr_ready_out, br_valid_out, br_taken_out, cc_out, phase_out,
               state_out, retire_cnt_out
    );

    modport master (
        output instr_valid_in, we_reg_in, br_in, nzp_mask_in, alu_result_in,
               flush_in, pc_ready_in,
        input  instr_ready_out, br_valid_out, br_taken_out, cc_out, phase_out,
               state_out, retire_cnt_out
    );
endinterface

// File: rtl/cc_branch_unit.sv
// Multi-phase execute unit: updates {n,z,p} condition codes from the ALU result and
// resolves conditional branches against the codes left by the previous writer.
module cc_branch_unit #(
    parameter int DATA_W = 16,
    parameter int PHASES = 2,
    parameter int CNT_W  = 8
) (
    input  logic            clka,
    input  logic            reset_in,
    cc_branch_unit_if.slave bus
);
    // Handshake: an instruction moves on an edge where instr_valid_in && instr_ready_out;
    // a branch decision moves on an edge where br_valid_out && pc_ready_in (RESOLVE only).
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        EXEC    = 2'b01,
        RESOLVE = 2'b10
    } state_t;

    localparam logic [2:0] LAST_PHASE = 3'(PHASES - 1);

    state_t           state_q, state_n;
    logic [2:0]       phase_q, phase_n;
    logic [2:0]       cc_q, cc_n;
    logic             valid_q, valid_n;
    logic             taken_q, taken_n;
    logic [CNT_W-1:0] retire_q, retire_n;
    logic             we_q, we_n;
    logic             br_q, br_n;
    logic [2:0]       mask_q, mask_n;

    function automatic logic [2:0] cc_of(input logic [DATA_W-1:0] r);
        if (r[DATA_W-1])  return 3'b100;
        else if (r == '0) return 3'b010;
        else              return 3'b001;
    endfunction

    always_ff @(negedge clka or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            cc_q     <= '0;
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            retire_q <= '0;
            we_q     <= 1'b0;
            br_q     <= 1'b0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_n;
            phase_q  <= phase_n;
            cc_q     <= cc_n;
            valid_q  <= valid_n;
            taken_q  <= taken_n;
            retire_q <= retire_n;
            we_q     <= we_n;
            br_q     <= br_n;
            mask_q   <= mask_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        phase_n  = phase_q;
        cc_n     = cc_q;
        valid_n  = valid_q;
        taken_n  = taken_q;
        retire_n = retire_q;
        we_n     = we_q;
        br_n     = br_q;
        mask_n   = mask_q;
        case (state_q)
            IDLE: begin
                if (bus.instr_valid_in && !bus.flush_in) begin
                    we_n    = bus.we_reg_in;
                    br_n    = bus.br_in;
                    mask_n  = bus.nzp_mask_in;
                    phase_n = '0;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (bus.flush_in) begin
                    state_n = IDLE;
                    phase_n = '0;
                    valid_n = 1'b0;
                    taken_n = 1'b0;
                end else if (phase_q == LAST_PHASE) begin
                    // The branch reads cc_q, i.e. the codes before this instruction's own update.
                    state_n = RESOLVE;
                    valid_n = 1'b1;
                    taken_n = br_q & (|(mask_q & cc_q));
                    if (we_q) cc_n = cc_of(bus.alu_result_in);
                end else begin
                    phase_n = phase_q + 3'd1;
                end
            end
            RESOLVE: begin
                if (bus.flush_in) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    taken_n = 1'b0;
                end else if (bus.pc_ready_in) begin
                    state_n  = IDLE;
                    valid_n  = 1'b0;
                    taken_n  = 1'b0;
                    retire_n = retire_q + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.instr_ready_out = (state_q == IDLE);
    assign bus.br_valid_out    = valid_q;
    assign bus.br_taken_out    = taken_q;
    assign bus.cc_out          = cc_q;
    assign bus.phase_out       = phase_q;
    assign bus.state_out       = state_q;
    assign bus.retire_cnt_out  = retire_q;
endmodule

// File: tb/tb_cc_branch_unit.sv
// Bench for cc_branch_unit: a PHASES=2/CNT_W=8 unit and a PHASES=1/CNT_W=2 unit share clock and reset.
// Expected codes, branch outcomes and retire counts come from a small instruction-level model.
module tb_cc_branch_unit;
  localparam int PH  = 2;
  localparam int PH2 = 1;

  logic clka = 1'b0;
  logic reset_in;
  int   total = 0;
  int   bad   = 0;

  logic [2:0] cc_m;
  int         retire_m;
  logic [3:0] exp_q[$];

  cc_branch_unit_if #(.DATA_W(16), .CNT_W(8)) m ();
  cc_branch_unit_if #(.DATA_W(16), .CNT_W(2)) s ();

  cc_branch_unit #(.DATA_W(16), .PHASES(PH), .CNT_W(8)) dut (
    .clka(clka), .reset_in(reset_in), .bus(m.slave));
  cc_branch_unit #(.DATA_W(16), .PHASES(PH2), .CNT_W(2)) dut2 (
    .clka(clka), .reset_in(reset_in), .bus(s.slave));

  // state updates on negedge; the bench drives and samples just after posedge
  always #5 clka = ~clka;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] ref_cc(input logic [15:0] r);
    if ($signed(r) < 0) return 3'b100;
    if (r == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  // Offers one instruction to the main unit, waits for its decision, holds pc_ready low
  // for 'hold' cycles, then completes with pc_ready (plus flush when end_flush).
  task automatic issue(input logic we, input logic br, input logic [2:0] mask,
                       input logic [15:0] alu, input int hold, input logic end_flush,
                       input logic noise, output int cyc, output logic taken,
                       output logic [2:0] cc_res, output logic stable, output logic tmo);
    m.instr_valid_in = 1'b1;
    m.we_reg_in      = we;
    m.br_in          = br;
    m.nzp_mask_in    = mask;
    m.alu_result_in  = alu;
    m.pc_ready_in    = 1'b0;
    m.flush_in       = 1'b0;
    cyc = 0;
    while (1) begin
      @(posedge clka);
      cyc++;
      if (m.state_out == 2'b10 || cyc >= 20) break;
      if (noise) begin
        m.instr_valid_in = 1'($urandom);
        m.pc_ready_in    = 1'($urandom);
        m.we_reg_in      = 1'($urandom);
        m.br_in          = 1'($urandom);
        m.nzp_mask_in    = 3'($urandom);
      end else begin
        m.instr_valid_in = 1'b0;
      end
    end
    m.instr_valid_in = 1'b0;
    m.pc_ready_in    = 1'b0;
    tmo    = (m.state_out != 2'b10);
    taken  = m.br_taken_out;
    cc_res = m.cc_out;
    stable = (m.br_valid_out === 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clka);
      if (m.br_valid_out !== 1'b1 || m.br_taken_out !== taken || m.state_out !== 2'b10)
        stable = 1'b0;
    end
    m.pc_ready_in = 1'b1;
    m.flush_in    = end_flush;
    @(posedge clka);
    m.pc_ready_in = 1'b0;
    m.flush_in    = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    repeat (2) @(posedge clka);
    total++; if (m.state_out !== 2'b00) begin bad++; $display("FAIL reset_state: got %0d want 0", m.state_out); end
    total++; if (m.phase_out !== 3'd0) begin bad++; $display("FAIL reset_phase: got %0d want 0", m.phase_out); end
    total++; if (m.cc_out !== 3'b000) begin bad++; $display("FAIL reset_cc: got %b want 000", m.cc_out); end
    total++; if (m.br_valid_out !== 1'b0 || m.br_taken_out !== 1'b0) begin bad++; $display("FAIL reset_br: got %b%b want 00", m.br_valid_out, m.br_taken_out); end
    total++; if (m.retire_cnt_out !== 8'd0) begin bad++; $display("FAIL reset_retire: got %0d want 0", m.retire_cnt_out); end
    total++; if (m.instr_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", m.instr_ready_out); end
    total++; if (s.state_out !== 2'b00 || s.retire_cnt_out !== 2'd0) begin bad++; $display("FAIL reset_dut2: got %0d/%0d want 0/0", s.state_out, s.retire_cnt_out); end
    reset_in = 1'b0;
    cc_m = 3'b000;
    retire_m = 0;
    @(posedge clka);
  endtask

  task automatic test_cc_neg();
    int cyc; logic tk, st, tmo; logic [2:0] ccr;
    issue(1'b1, 1'b0, 3'b000, 16'h8000, 0, 1'b0, 1'b0, cyc, tk, ccr, st, tmo);
    cc_m = ref_cc(16'h8000);
    retire_m++;
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL neg_resolve_entry: got timeout=%b want 0", tmo); end
    // acceptance edge plus PHASES exec edges before RESOLVE is visible
    total++; if (cyc != PH + 1) begin bad++; $display("FAIL neg_latency: got %0d want %0d", cyc, PH + 1); end
    total++; if (ccr !== cc_m) begin bad++; $display("FAIL neg_cc: got %b want %b", ccr, cc_m); end
    total++; if (tk !== 1'b0) begin bad++; $display("FAIL neg_taken: got %b want 0", tk); end
    total++; if (m.br_valid_out !== 1'b0 || m.state_out !== 2'b00) begin bad++; $display("FAIL neg_after: got valid=%b state=%0d want 0/0", m.br_valid_out, m.state_out); end
    total++; if (m.retire_cnt_out !== 8'(retire_m)) begin bad++; $display("FAIL neg_retire: got %0d want %0d", m.retire_cnt_out, retire_m); end
  endtask

  task automatic test_branch_zero();
    int cyc; logic tk, st, tmo; logic [2:0] ccr;
    issue(1'b1, 1'b0, 3'b000, 16'h0000, 0, 1'b0, 1'b0, cyc, tk, ccr, st, tmo);
    cc_m = ref_cc(16'h0000); retire_m++;
    total++; if (ccr !== 3'b010) begin bad++; $display("FAIL zero_cc: got %b want 010", ccr); end
    issue(1'b0, 1'b1, 3'b010, 16'($urandom), 0, 1'b0, 1'b0, cyc, tk, ccr, st, tmo);
    retire_m++;
    total++; if (tk !== 1'b1) begin bad++; $display("FAIL br_z_taken: got %b want 1", tk); end
    issue(1'b0, 1'b1, 3'b101, 16'($urandom), 0, 1'b0, 1'b0, cyc, tk, ccr, st, tmo);
    retire_m++;
    total++; if (tk !== 1'b0) begin bad++; $display("FAIL br_np_taken: got %b want 0", tk); end
    total++; if (m.cc_out !== cc_m) begin bad++; $display("FAIL br_cc_kept: got %b want %b", m.cc_out, cc_m); end
  endtask

  task automatic test_br_and_we();
    int cyc; logic tk, st, tmo; logic [2:0] ccr;
    issue(1'b1, 1'b1, 3'b001, 16'd5, 0, 1'b0, 1'b0, cyc, tk, ccr, st, tmo);
    cc_m = ref_cc(16'd5); retire_m++;
    total++; if (tk !== 1'b0) begin bad++; $display("FAIL brwe_taken: got %b want 0", tk); end
    total++; if (m.cc_out !== 3'b001) begin bad++; $display("FAIL brwe_cc: got %b want 001", m.cc_out); end
  endtask

  task automatic test_stall_flush();
    int cyc; logic tk, st, tmo; logic [2:0] ccr;
    issue(1'b0, 1'b1, 3'b001, 16'd0, 4, 1'b1, 1'b0, cyc, tk, ccr, st, tmo);
    total++; if (tk !== 1'b1) begin bad++; $display("FAIL stall_taken: got %b want 1", tk); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL stall_stable: got %b want 1", st); end
    total++; if (m.state_out !== 2'b00 || m.br_valid_out !== 1'b0 || m.br_taken_out !== 1'b0) begin bad++; $display("FAIL stall_flush_idle: got state=%0d valid=%b taken=%b want 0/0/0", m.state_out, m.br_valid_out, m.br_taken_out); end
    total++; if (m.retire_cnt_out !== 8'(retire_m)) begin bad++; $display("FAIL stall_flush_retire: got %0d want %0d", m.retire_cnt_out, retire_m); end
  endtask

  task automatic test_flush_exec();
    m.instr_valid_in = 1'b1; m.we_reg_in = 1'b1; m.br_in = 1'b0;
    m.nzp_mask_in = 3'b000; m.alu_result_in = 16'h8000;
    @(posedge clka);
    m.instr_valid_in = 1'b0;
    total++; if (m.state_out !== 2'b01 || m.phase_out !== 3'd0) begin bad++; $display("FAIL fexec_enter: got state=%0d phase=%0d want 1/0", m.state_out, m.phase_out); end
    m.flush_in = 1'b1;
    @(posedge clka);
    m.flush_in = 1'b0;
    total++; if (m.state_out !== 2'b00) begin bad++; $display("FAIL fexec_idle: got %0d want 0", m.state_out); end
    repeat (3) @(posedge clka);
    total++; if (m.cc_out !== cc_m) begin bad++; $display("FAIL fexec_cc: got %b want %b", m.cc_out, cc_m); end
    total++; if (m.retire_cnt_out !== 8'(retire_m) || m.br_valid_out !== 1'b0) begin bad++; $display("FAIL fexec_retire: got %0d valid=%b want %0d/0", m.retire_cnt_out, m.br_valid_out, retire_m); end
  endtask

  task automatic test_random();
    int cyc; logic tk, st, tmo; logic [2:0] ccr;
    logic we, br; logic [2:0] mask; logic [15:0] alu; logic [3:0] e;
    for (int n = 0; n < 25; n++) begin
      we   = 1'($urandom);
      br   = 1'($urandom);
      mask = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       alu = 16'h0000;
        1:       alu = 16'h8000 | 16'($urandom);
        default: alu = 16'($urandom);
      endcase
      e = {br & (|(mask & cc_m)), (we ? ref_cc(alu) : cc_m)};
      exp_q.push_back(e);
      issue(we, br, mask, alu, $urandom_range(0, 3), 1'b0, 1'b1, cyc, tk, ccr, st, tmo);
      if (we) cc_m = ref_cc(alu);
      retire_m++;
      e = exp_q.pop_front();
      total++; if ({tk, ccr} !== e || tmo !== 1'b0) begin bad++; $display("FAIL rand_decision[%0d]: got taken=%b cc=%b tmo=%b want taken=%b cc=%b", n, tk, ccr, tmo, e[3], e[2:0]); end
      total++; if (st !== 1'b1 || cyc != PH + 1) begin bad++; $display("FAIL rand_timing[%0d]: got stable=%b cyc=%0d want 1/%0d", n, st, cyc, PH + 1); end
      total++; if (m.retire_cnt_out !== 8'(retire_m) || m.state_out !== 2'b00) begin bad++; $display("FAIL rand_retire[%0d]: got %0d state=%0d want %0d/0", n, m.retire_cnt_out, m.state_out, retire_m); end
    end
  endtask

  task automatic test_wrap_phases1();
    int cyc; int r2 = 0; logic [2:0] cc2 = 3'b000; logic [15:0] a;
    for (int k = 0; k < 4; k++) begin
      a = 16'($urandom);
      s.instr_valid_in = 1'b1; s.we_reg_in = 1'b1; s.br_in = 1'b0;
      s.nzp_mask_in = 3'b111; s.alu_result_in = a; s.pc_ready_in = 1'b1;
      @(posedge clka);
      s.instr_valid_in = 1'b0;
      total++; if (s.state_out !== 2'b01) begin bad++; $display("FAIL p1_accept[%0d]: got %0d want 1", k, s.state_out); end
      cyc = 0;
      do begin @(posedge clka); cyc++; end while (s.state_out != 2'b00 && cyc < 10);
      cc2 = ref_cc(a);
      r2  = (r2 + 1) % 4;
      total++; if (cyc != PH2 + 1) begin bad++; $display("FAIL p1_latency[%0d]: got %0d want %0d", k, cyc, PH2 + 1); end
      total++; if (s.retire_cnt_out !== 2'(r2) || s.cc_out !== cc2) begin bad++; $display("FAIL p1_retire_cc[%0d]: got %0d/%b want %0d/%b", k, s.retire_cnt_out, s.cc_out, r2, cc2); end
    end
    s.pc_ready_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc; logic tk, st, tmo; logic [2:0] ccr;
    m.instr_valid_in = 1'b1; m.we_reg_in = 1'b1; m.br_in = 1'b1;
    m.nzp_mask_in = 3'b111; m.alu_result_in = 16'd9;
    @(posedge clka);
    m.instr_valid_in = 1'b0;
    @(posedge clka);
    total++; if (m.phase_out !== 3'd1) begin bad++; $display("FAIL rmid_phase: got %0d want 1", m.phase_out); end
    #2 reset_in = 1'b1;
    #1;
    total++; if (m.state_out !== 2'b00 || m.phase_out !== 3'd0 || m.cc_out !== 3'b000) begin bad++; $display("FAIL rmid_clear: got state=%0d phase=%0d cc=%b want 0/0/000", m.state_out, m.phase_out, m.cc_out); end
    total++; if (m.retire_cnt_out !== 8'd0 || m.br_valid_out !== 1'b0 || m.br_taken_out !== 1'b0) begin bad++; $display("FAIL rmid_clear_br: got retire=%0d valid=%b taken=%b want 0/0/0", m.retire_cnt_out, m.br_valid_out, m.br_taken_out); end
    #1 reset_in = 1'b0;
    cc_m = 3'b000; retire_m = 0;
    @(posedge clka);
    // with cleared codes no mask can select a set bit
    issue(1'b0, 1'b1, 3'b111, 16'd0, 0, 1'b0, 1'b0, cyc, tk, ccr, st, tmo);
    retire_m++;
    total++; if (tk !== 1'b0 || ccr !== 3'b000) begin bad++; $display("FAIL rmid_branch: got taken=%b cc=%b want 0/000", tk, ccr); end
    total++; if (m.retire_cnt_out !== 8'(retire_m)) begin bad++; $display("FAIL rmid_retire: got %0d want %0d", m.retire_cnt_out, retire_m); end
  endtask

  initial begin
    m.instr_valid_in = 1'b0; m.we_reg_in = 1'b0; m.br_in = 1'b0; m.nzp_mask_in = 3'b000;
    m.alu_result_in = 16'd0; m.flush_in = 1'b0; m.pc_ready_in = 1'b0;
    s.instr_valid_in = 1'b0; s.we_reg_in = 1'b0; s.br_in = 1'b0; s.nzp_mask_in = 3'b000;
    s.alu_result_in = 16'd0; s.flush_in = 1'b0; s.pc_ready_in = 1'b0;
    test_reset();
    test_wrap_phases1();
    test_cc_neg();
    test_branch_zero();
    test_br_and_we();
    test_stall_flush();
    test_flush_exec();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
